mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single-port word memory with wait states.
// Define MEM_ARB_RR_EN to replace fixed data-port priority with round-robin tie breaking.
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16384,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                im_req,
    input  logic [ADDR_W-1:0]   im_addr,
    output logic                im_ready,
    output logic [DATA_W-1:0]   im_rdata,
    input  logic                dm_req,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W/8-1:0] dm_web,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic                dm_ready,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                busy
);

    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = $clog2(LANES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state;
    state_t             next_state;
    logic               grant_dm;
    logic [IDX_W-1:0]   addr_q;
    logic [LANES-1:0]   web_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [3:0]         cnt;
    logic [DATA_W-1:0]  rd_word;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic               take_dm;
    logic               cur_dm;
    logic [IDX_W-1:0]   cur_idx;
    logic [LANES-1:0]   cur_web;
    logic [DATA_W-1:0]  cur_wdata;
    logic [DATA_W-1:0]  merged;
    logic               enter_resp;

`ifdef MEM_ARB_RR_EN
    // last_dm remembers who won the previous grant; 0 (IM) after reset so DM wins the first tie
    logic last_dm;

    always_comb take_dm = dm_req && (!im_req || !last_dm);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_dm <= 1'b0;
        else if (state == IDLE && (im_req || dm_req))
            last_dm <= take_dm;
    end
`else
    always_comb take_dm = dm_req;
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (im_req || dm_req) next_state = (WAIT_CYCLES > 0) ? WAIT : RESP;
            WAIT:    if (cnt == 4'd0) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // In IDLE the access being granted comes straight from the ports, so a zero-wait
    // write can commit on the same edge it is granted; afterwards only latched values count.
    always_comb begin
        cur_dm    = grant_dm;
        cur_idx   = addr_q;
        cur_web   = web_q;
        cur_wdata = wdata_q;
        if (state == IDLE) begin
            cur_dm    = take_dm;
            cur_idx   = take_dm ? dm_addr[OFF_W +: IDX_W] : im_addr[OFF_W +: IDX_W];
            cur_web   = take_dm ? dm_web : '1;
            cur_wdata = take_dm ? dm_wdata : '0;
        end
        merged = mem[cur_idx];
        for (int i = 0; i < LANES; i++)
            if (!cur_web[i]) merged[8*i +: 8] = cur_wdata[8*i +: 8];
        enter_resp = rst && (next_state == RESP) && (state != RESP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            grant_dm <= 1'b0;
            addr_q   <= '0;
            web_q    <= '1;
            wdata_q  <= '0;
            cnt      <= 4'd0;
        end else begin
            state <= next_state;
            if (state == IDLE && (im_req || dm_req)) begin
                grant_dm <= cur_dm;
                addr_q   <= cur_idx;
                web_q    <= cur_web;
                wdata_q  <= cur_wdata;
                cnt      <= CNT_INIT;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Storage is deliberately not reset; rd_word is only visible while RESP gates it out.
    always_ff @(posedge clk) begin
        if (enter_resp) begin
            for (int i = 0; i < LANES; i++)
                if (!cur_web[i]) mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
            rd_word <= merged;
        end
    end

    assign busy     = (state != IDLE);
    assign im_ready = (state == RESP) && !grant_dm;
    assign dm_ready = (state == RESP) && grant_dm;
    assign im_rdata = im_ready ? rd_word : '0;
    assign dm_rdata = dm_ready ? rd_word : '0;

endmodule
